alu_sequencer: RTL and testbench

Sequences the two-operand ALU for the AVR-style core. Accepts 16-bit instruction words from fetch and decodes the register-register ALU group (ADD, ADC, SUB, SBC, CP, CPC, CPSE, AND, EOR, OR, MOV). Reads Rd/Rr from the register file, drives the ALU for one registered cycle, then writes back the result and SREG. Owns SREG and resolves CPSE skips, including two-word skips when configured.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/alu_decode.sv | 27 ++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the AVR-style ALU sequencer: op codes, SREG bit
// indices, sequencer states and the decoded-instruction record.
// The SKIP2 state only exists when ALU_SEQUENCER_SKIP2_EN is defined.
package alu_pkg;

  // ALU op codes, taken straight from instruction bits [13:10]
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_CPC  = 4'b0001;
  localparam logic [3:0] OP_SBC  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_CPSE = 4'b0100;
  localparam logic [3:0] OP_CP   = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_ADC  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_MOV  = 4'b1011;

  // SREG bit positions, {I,T,H,S,V,N,Z,C}
  localparam int SREG_I = 7;
  localparam int SREG_T = 6;
  localparam int SREG_H = 5;
  localparam int SREG_S = 4;
  localparam int SREG_V = 3;
  localparam int SREG_N = 2;
  localparam int SREG_Z = 1;
  localparam int SREG_C = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    SKIP  = 3'd3
`ifdef ALU_SEQUENCER_SKIP2_EN
    , SKIP2 = 3'd4
`endif
  } state_t;

  typedef struct packed {
    logic       is_alu;
    logic [3:0] op;
    logic [4:0] rd;
    logic [4:0] rr;
    logic       writes_rf;
    logic       writes_sreg;
    logic       is_two_word;
  } decode_t;

  // LDS, STS, JMP and CALL carry a second word that must be skipped as well
  function automatic logic two_word_opcode(input logic [15:0] w);
    return ((w & 16'hFE0F) == 16'h9000) ||
           ((w & 16'hFE0F) == 16'h9200) ||
           ((w & 16'hFE0C) == 16'h940C);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder for the register-register ALU group.
module alu_decode
  import alu_pkg::*;
(
  input  logic [15:0] instr,
  output decode_t     dec
);

  // Field extraction and per-op writeback / flag-update classification
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    dec             = '0;
    dec.op          = instr[13:10];
    dec.rd          = instr[8:4];
    dec.rr          = {instr[9], instr[3:0]};
    dec.is_alu      = (instr[15:14] == 2'b00) && (instr[13:10] != OP_NOP);
    dec.is_two_word = two_word_opcode(instr);
    case (instr[13:10])
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_AND, OP_EOR, OP_OR,  OP_MOV: dec.writes_rf = dec.is_alu;
      default:                        dec.writes_rf = 1'b0;
    endcase
    dec.writes_sreg = dec.is_alu && (instr[13:10] != OP_MOV) && (instr[13:10] != OP_CPSE);
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts instruction words, reads Rd/Rr, drives the external
// ALU for one cycle, writes back the result and SREG, and resolves CPSE skips.
// Define ALU_SEQUENCER_SKIP2_EN to let CPSE skip a two-word instruction whole.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  output logic        o_done,
  output logic        o_nonalu,
  output logic [4:0]  o_rf_raddr_d,
  output logic [4:0]  o_rf_raddr_r,
  input  logic [7:0]  i_rf_rdata_d,
  input  logic [7:0]  i_rf_rdata_r,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [7:0]  o_rf_wdata,
  output logic [3:0]  o_alu_operation,
  output logic [7:0]  o_alu_op1,
  output logic [7:0]  o_alu_op2,
  output logic [5:0]  o_alu_flags,
  input  logic [7:0]  i_alu_result,
  input  logic [5:0]  i_alu_flags,
  input  logic        i_sreg_we,
  input  logic [7:0]  i_sreg_wdata,
  output logic [7:0]  o_sreg
);

  state_t     state, state_next;
  decode_t    dec;
  logic       load_instr;
  logic [3:0] op_q;
  logic [4:0] rd_q, rr_q;
  logic       writes_rf_q, writes_sreg_q;
  logic [7:0] sreg_q;

  alu_decode u_decode (
    .instr (i_instr),
    .dec   (dec)
  );

`ifndef ALU_SEQUENCER_SKIP2_EN
  // Two-word detection only matters when two-word skips are enabled
  logic unused_two_word;
  assign unused_two_word = dec.is_two_word;
`endif

  // State register and latch of the accepted instruction's fields
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      state         <= IDLE;
      op_q          <= OP_NOP;
      rd_q          <= '0;
      rr_q          <= '0;
      writes_rf_q   <= 1'b0;
      writes_sreg_q <= 1'b0;
    end else begin
      state <= state_next;
      if (load_instr) begin
        op_q          <= dec.op;
        rd_q          <= dec.rd;
        rr_q          <= dec.rr;
        writes_rf_q   <= dec.writes_rf;
        writes_sreg_q <= dec.writes_sreg;
      end
    end
  end

  // SREG: external writes land only in IDLE; ALU flags land at the EXEC edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sreg_q <= 8'h00;
    end else if (state == IDLE && i_sreg_we) begin
      sreg_q <= i_sreg_wdata;
    end else if (state == EXEC && writes_sreg_q) begin
      sreg_q[SREG_H:SREG_C] <= i_alu_flags;
    end
  end

  // Next-state and output decode; everything idles low while in reset
  always_comb begin
    state_next      = state;
    load_instr      = 1'b0;
    o_instr_ready   = 1'b0;
    o_done          = 1'b0;
    o_nonalu        = 1'b0;
    o_rf_we         = 1'b0;
    o_alu_operation = OP_NOP;
    o_alu_op1       = 8'h00;
    o_alu_op2       = 8'h00;
    o_alu_flags     = 6'h00;
    if (!i_reset) begin
      case (state)
        IDLE: begin
          o_instr_ready = 1'b1;
          if (i_instr_valid) begin
            if (dec.is_alu) begin
              load_instr = 1'b1;
              state_next = READ;
            end else begin
              o_nonalu = 1'b1;
            end
          end
        end
        READ: begin
          o_alu_operation = op_q;
          o_alu_op1       = i_rf_rdata_d;
          o_alu_op2       = i_rf_rdata_r;
          o_alu_flags     = sreg_q[SREG_H:SREG_C];
          state_next      = EXEC;
        end
        EXEC: begin
          o_done     = 1'b1;
          o_rf_we    = writes_rf_q;
          state_next = (op_q == OP_CPSE && i_alu_result == 8'h00) ? SKIP : IDLE;
        end
        SKIP: begin
          // The discarded word never reports as non-ALU
          o_instr_ready = 1'b1;
          if (i_instr_valid) begin
`ifdef ALU_SEQUENCER_SKIP2_EN
            state_next = dec.is_two_word ? SKIP2 : IDLE;
`else
            state_next = IDLE;
`endif
          end
        end
`ifdef ALU_SEQUENCER_SKIP2_EN
        SKIP2: begin
          o_instr_ready = 1'b1;
          if (i_instr_valid) state_next = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  assign o_rf_raddr_d = rd_q;
  assign o_rf_raddr_r = rr_q;
  assign o_rf_waddr   = rd_q;
  assign o_rf_wdata   = o_rf_we ? i_alu_result : 8'h00;
  assign o_sreg       = sreg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: models the register file and ALU,
// predicts register and SREG contents from instruction semantics.
module tb_alu_sequencer;

  localparam logic [3:0] A_NOP = 4'b0000, A_CPC = 4'b0001, A_SBC = 4'b0010,
                         A_ADD = 4'b0011, A_CPSE = 4'b0100, A_CP = 4'b0101,
                         A_SUB = 4'b0110, A_ADC = 4'b0111, A_AND = 4'b1000,
                         A_EOR = 4'b1001, A_OR = 4'b1010, A_MOV = 4'b1011;

  logic        i_clk, i_reset, i_instr_valid, i_sreg_we;
  logic [15:0] i_instr;
  logic [7:0]  i_sreg_wdata, i_rf_rdata_d, i_rf_rdata_r, i_alu_result;
  logic [5:0]  i_alu_flags;
  logic        o_instr_ready, o_done, o_nonalu, o_rf_we;
  logic [4:0]  o_rf_raddr_d, o_rf_raddr_r, o_rf_waddr;
  logic [7:0]  o_rf_wdata, o_alu_op1, o_alu_op2, o_sreg;
  logic [3:0]  o_alu_operation;
  logic [5:0]  o_alu_flags;

  int errors = 0, checks = 0, cyc = 0, done_count = 0;
  logic [7:0] rf [32];
  logic [7:0] model_rf [32];
  logic [7:0] exp_sreg = 8'h00;
  logic       pre_we = 1'b0;
  logic [4:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] alu_res = 8'h00;
  logic [5:0] alu_fl = 6'h00;

  alu_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready), .o_done(o_done), .o_nonalu(o_nonalu),
    .o_rf_raddr_d(o_rf_raddr_d), .o_rf_raddr_r(o_rf_raddr_r),
    .i_rf_rdata_d(i_rf_rdata_d), .i_rf_rdata_r(i_rf_rdata_r),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_alu_operation(o_alu_operation), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
    .o_alu_flags(o_alu_flags), .i_alu_result(i_alu_result), .i_alu_flags(i_alu_flags),
    .i_sreg_we(i_sreg_we), .i_sreg_wdata(i_sreg_wdata), .o_sreg(o_sreg)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (o_done === 1'b1) done_count <= done_count + 1;

  // AVR arithmetic in plain integer terms; returns {result, H,S,V,N,Z,C}
  function automatic logic [13:0] avr_alu(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [5:0] f);
    int ci, u, sgn, hn;
    logic [7:0] r;
    logic h, v, c, z;
    h = f[5]; v = f[3]; c = f[0]; r = 8'h00; ci = 0; u = 0; sgn = 0; hn = 0;
    if (op == A_ADC || op == A_SBC || op == A_CPC) ci = int'(f[0]);
    case (op)
      A_ADD, A_ADC: begin
        u = int'(a) + int'(b) + ci;
        sgn = int'($signed(a)) + int'($signed(b)) + ci;
        hn = int'(a[3:0]) + int'(b[3:0]) + ci;
        r = u[7:0]; c = (u > 255); h = (hn > 15); v = (sgn > 127) || (sgn < -128);
      end
      A_SUB, A_SBC, A_CP, A_CPC: begin
        u = int'(a) - int'(b) - ci;
        sgn = int'($signed(a)) - int'($signed(b)) - ci;
        hn = int'(a[3:0]) - int'(b[3:0]) - ci;
        r = u[7:0]; c = (u < 0); h = (hn < 0); v = (sgn > 127) || (sgn < -128);
      end
      A_AND: begin r = a & b; v = 1'b0; end
      A_EOR: begin r = a ^ b; v = 1'b0; end
      A_OR:  begin r = a | b; v = 1'b0; end
      A_MOV: return {b, f};
      default: return {a ^ b, f};
    endcase
    z = (r == 8'h00);
    if (op == A_SBC || op == A_CPC) z = z && f[1];
    return {r, h, r[7] ^ v, v, r[7], z, c};
  endfunction

  function automatic logic writes_rf(input logic [3:0] op);
    return op inside {A_ADD, A_ADC, A_SUB, A_SBC, A_AND, A_EOR, A_OR, A_MOV};
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rr);
    return {2'b00, op, rr[4], rd, rr[3:0]};
  endfunction

  // Register file (combinational read) and one-cycle ALU environment
  assign i_rf_rdata_d = rf[o_rf_raddr_d];
  assign i_rf_rdata_r = rf[o_rf_raddr_r];
  always @(posedge i_clk) begin
    if (o_rf_we === 1'b1) rf[o_rf_waddr] <= o_rf_wdata;
    if (pre_we) rf[pre_addr] <= pre_data;
  end
  always @(posedge i_clk)
    if (o_alu_operation != A_NOP)
      {alu_res, alu_fl} <= avr_alu(o_alu_operation, o_alu_op1, o_alu_op2, o_alu_flags);
  assign i_alu_result = alu_res;
  assign i_alu_flags  = alu_fl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_reg(input logic [4:0] a, input logic [7:0] v);
    @(negedge i_clk); pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(posedge i_clk); #1 pre_we = 1'b0;
    model_rf[a] = v;
  endtask

  task automatic set_sreg(input logic [7:0] v);
    @(negedge i_clk); i_sreg_we = 1'b1; i_sreg_wdata = v;
    @(posedge i_clk); #1 i_sreg_we = 1'b0;
    exp_sreg = v;
  endtask

  // Offer one word until accepted; reports the accept cycle and o_nonalu
  task automatic push(input logic [15:0] w, input bit swe, input logic [7:0] sval,
                      output int acc, output bit nonalu);
    acc = -1; nonalu = 1'b0;
    @(negedge i_clk);
    i_instr = w; i_instr_valid = 1'b1; i_sreg_we = swe; i_sreg_wdata = sval;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (o_instr_ready === 1'b1) begin acc = cyc; nonalu = o_nonalu; break; end
      @(negedge i_clk);
    end
    checks++;
    if (acc < 0) begin errors++; $display("FAIL accept_timeout: word %h not accepted", w); end
    @(posedge i_clk); #1 i_instr_valid = 1'b0; i_sreg_we = 1'b0;
  endtask

  // Issue one ALU word and check latency, write enable, Rd and SREG
  task automatic run_alu(input logic [15:0] w, input bit swe, input logic [7:0] sval,
                         output int acc, output bit we_seen);
    logic [3:0] op; logic [4:0] rd, rr; logic [13:0] m; bit nal, wr; int dcyc;
    op = w[13:10]; rd = w[8:4]; rr = {w[9], w[3:0]};
    if (swe) exp_sreg = sval;
    m = avr_alu(op, model_rf[rd], model_rf[rr], exp_sreg[5:0]);
    wr = writes_rf(op);
    push(w, swe, sval, acc, nal);
    checks++;
    if (nal !== 1'b0) begin errors++; $display("FAIL nonalu_on_alu %h: got %b want 0", w, nal); end
    dcyc = -1; we_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin dcyc = cyc; we_seen = o_rf_we; break; end
    end
    checks++;
    if (dcyc !== acc + 2) begin errors++; $display("FAIL done_latency %h: got cycle %0d want %0d", w, dcyc, acc + 2); end
    checks++;
    if (we_seen !== wr) begin errors++; $display("FAIL rf_we %h: got %b want %b", w, we_seen, wr); end
    if (wr) model_rf[rd] = m[13:6];
    if (op != A_MOV && op != A_CPSE) exp_sreg[5:0] = m[5:0];
    @(posedge i_clk); #1;
    checks++;
    if (rf[rd] !== model_rf[rd]) begin errors++; $display("FAIL rd_value %h: got %h want %h", w, rf[rd], model_rf[rd]); end
    checks++;
    if (o_sreg !== exp_sreg) begin errors++; $display("FAIL sreg %h: got %h want %h", w, o_sreg, exp_sreg); end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_instr = 16'h0C12; i_instr_valid = 1'b1; i_sreg_we = 1'b0; i_sreg_wdata = 8'h00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_instr_ready, o_done, o_nonalu, o_rf_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {o_instr_ready, o_done, o_nonalu, o_rf_we});
    end
    checks++;
    if (o_sreg !== 8'h00 || o_alu_operation !== A_NOP) begin
      errors++; $display("FAIL reset_sreg_op: got sreg %h op %h want 00 0", o_sreg, o_alu_operation);
    end
    i_instr_valid = 1'b0; i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", o_instr_ready); end
    for (int i = 0; i < 32; i++) set_reg(5'(i), 8'($urandom));
    exp_sreg = 8'h00;
  endtask

  task automatic test_add();
    int acc; bit we;
    set_reg(1, 8'h0F); set_reg(2, 8'h01);
    run_alu(16'h0C12, 1'b0, 8'h00, acc, we);
    checks++;
    if (rf[1] !== 8'h10 || o_sreg !== 8'h20) begin
      errors++; $display("FAIL add_directed: got r1=%h sreg=%h want 10 20", rf[1], o_sreg);
    end
  endtask

  task automatic test_sub();
    int acc; bit we;
    set_reg(16, 8'h00); set_reg(17, 8'h01);
    run_alu(16'h1B01, 1'b0, 8'h00, acc, we);
    checks++;
    if (rf[16] !== 8'hFF || o_sreg !== 8'h35) begin
      errors++; $display("FAIL sub_directed: got r16=%h sreg=%h want ff 35", rf[16], o_sreg);
    end
  endtask

  task automatic test_cpc();
    int acc; bit we;
    set_reg(0, 8'h05); set_reg(1, 8'h05);
    set_sreg(8'h02);
    run_alu(16'h0401, 1'b0, 8'h00, acc, we);
    checks++;
    if (o_sreg[1] !== 1'b1 || we !== 1'b0 || rf[0] !== 8'h05) begin
      errors++; $display("FAIL cpc_z_kept: got Z=%b we=%b r0=%h want 1 0 05", o_sreg[1], we, rf[0]);
    end
    set_sreg(8'h00);
    run_alu(16'h0401, 1'b0, 8'h00, acc, we);
    checks++;
    if (o_sreg[1] !== 1'b0 || we !== 1'b0 || rf[0] !== 8'h05) begin
      errors++; $display("FAIL cpc_z_clear: got Z=%b we=%b r0=%h want 0 0 05", o_sreg[1], we, rf[0]);
    end
  endtask

  task automatic test_mov();
    int acc; bit we;
    set_reg(6, 8'hA5);
    set_sreg(8'hFF);
    run_alu(16'h2C56, 1'b0, 8'h00, acc, we);
    checks++;
    if (rf[5] !== 8'hA5 || o_sreg !== 8'hFF) begin
      errors++; $display("FAIL mov_directed: got r5=%h sreg=%h want a5 ff", rf[5], o_sreg);
    end
  endtask

  task automatic test_sreg_ext();
    int acc; bit we, nal; logic [13:0] m;
    set_sreg(8'h00); set_reg(1, 8'h10); set_reg(2, 8'h20);
    // write coinciding with accept: ADC sees C=1
    run_alu(mk(A_ADC, 1, 2), 1'b1, 8'h01, acc, we);
    checks++;
    if (rf[1] !== 8'h31) begin errors++; $display("FAIL adc_new_carry: got %h want 31", rf[1]); end
    // write attempted during READ/EXEC must be ignored
    m = avr_alu(A_ADD, model_rf[1], model_rf[2], exp_sreg[5:0]);
    push(mk(A_ADD, 1, 2), 1'b0, 8'h00, acc, nal);
    @(negedge i_clk); i_sreg_we = 1'b1; i_sreg_wdata = 8'hFF;
    @(negedge i_clk);
    @(posedge i_clk); #1 i_sreg_we = 1'b0;
    model_rf[1] = m[13:6]; exp_sreg[5:0] = m[5:0];
    checks++;
    if (o_sreg !== exp_sreg || rf[1] !== model_rf[1]) begin
      errors++; $display("FAIL sreg_ext_ignored: got sreg=%h r1=%h want %h %h", o_sreg, rf[1], exp_sreg, model_rf[1]);
    end
  endtask

  task automatic test_cpse();
    int acc, d0; bit we, nal; logic [7:0] s0;
    set_reg(3, 8'($urandom));
    run_alu(16'h1033, 1'b0, 8'h00, acc, we);
    s0 = exp_sreg; d0 = done_count;
    push(16'h940C, 1'b0, 8'h00, acc, nal);
    checks++;
    if (nal !== 1'b0) begin errors++; $display("FAIL skip_first: got nonalu %b want 0", nal); end
    push(16'h0000, 1'b0, 8'h00, acc, nal);
    checks++;
`ifdef ALU_SEQUENCER_SKIP2_EN
    if (nal !== 1'b0) begin errors++; $display("FAIL skip_second: got nonalu %b want 0", nal); end
`else
    if (nal !== 1'b1) begin errors++; $display("FAIL skip_second: got nonalu %b want 1", nal); end
`endif
    checks++;
    if (o_sreg !== s0 || done_count !== d0) begin
      errors++; $display("FAIL skip_side_effects: got sreg=%h dones=%0d want %h %0d", o_sreg, done_count - d0, s0, 0);
    end
    set_reg(1, 8'($urandom)); set_reg(2, 8'($urandom));
    run_alu(16'h0C12, 1'b0, 8'h00, acc, we);
    // single-word discard after an equal compare
    run_alu(16'h1033, 1'b0, 8'h00, acc, we);
    push(16'h0000, 1'b0, 8'h00, acc, nal);
    push(16'h0001, 1'b0, 8'h00, acc, nal);
    checks++;
    if (nal !== 1'b1) begin errors++; $display("FAIL skip_one_word: got nonalu %b want 1", nal); end
    // unequal compare does not skip
    set_reg(4, model_rf[3] + 8'h01);
    run_alu(mk(A_CPSE, 3, 4), 1'b0, 8'h00, acc, we);
    push(16'h0000, 1'b0, 8'h00, acc, nal);
    checks++;
    if (nal !== 1'b1) begin errors++; $display("FAIL cpse_no_skip: got nonalu %b want 1", nal); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2; bit we, nal;
    run_alu(mk(A_ADD, 7, 8), 1'b0, 8'h00, a0, we);
    run_alu(mk(A_EOR, 9, 7), 1'b0, 8'h00, a1, we);
    checks++;
    if (a1 - a0 !== 3) begin errors++; $display("FAIL alu_throughput: got %0d cycles want 3", a1 - a0); end
    push(16'hF000, 1'b0, 8'h00, a0, nal);
    push(16'h9000, 1'b0, 8'h00, a2, nal);
    checks++;
    if (a2 - a0 !== 1 || nal !== 1'b1) begin
      errors++; $display("FAIL nonalu_throughput: got %0d cycles nonalu=%b want 1 1", a2 - a0, nal);
    end
  endtask

  task automatic test_reset_mid();
    int acc; bit nal;
    set_reg(1, 8'h0F); set_reg(2, 8'h01); set_sreg(8'hC3);
    push(16'h0C12, 1'b0, 8'h00, acc, nal);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1; #1;
    checks++;
    if (o_rf_we !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_exec_we: got we=%b done=%b want 0 0", o_rf_we, o_done);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_sreg !== 8'h00 || o_instr_ready !== 1'b0 || rf[1] !== 8'h0F) begin
      errors++; $display("FAIL reset_exec_state: got sreg=%h ready=%b r1=%h want 00 0 0f", o_sreg, o_instr_ready, rf[1]);
    end
    @(negedge i_clk); i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_instr_ready !== 1'b1) begin errors++; $display("FAIL reset_exec_ready: got %b want 1", o_instr_ready); end
    exp_sreg = 8'h00;
  endtask

  task automatic test_random();
    logic [3:0] ops [10] = '{A_ADD, A_ADC, A_SUB, A_SBC, A_CP, A_CPC, A_AND, A_EOR, A_OR, A_MOV};
    int acc; bit we, nal, swe; logic [15:0] w; logic [7:0] sv; logic [4:0] rd, rr;
    for (int n = 0; n < 60; n++) begin
      swe = ($urandom_range(0, 3) == 0);
      sv  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        w = 16'($urandom);
        if (w[15:14] == 2'b00) w[13:10] = 4'b0000;
        push(w, swe, sv, acc, nal);
        if (swe) exp_sreg = sv;
        checks++;
        if (nal !== 1'b1 || o_sreg !== exp_sreg) begin
          errors++; $display("FAIL rand_nonalu %h: got nonalu=%b sreg=%h want 1 %h", w, nal, o_sreg, exp_sreg);
        end
      end else begin
        rd = 5'($urandom); rr = 5'($urandom);
        if ($urandom_range(0, 1) == 1) set_reg(rd, 8'($urandom));
        run_alu(mk(ops[$urandom_range(0, 9)], rd, rr), swe, sv, acc, we);
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf[i] !== model_rf[i]) begin errors++; $display("FAIL final_rf r%0d: got %h want %h", i, rf[i], model_rf[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cpc();
    test_mov();
    test_sreg_ext();
    test_cpse();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
